// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: one SDRAM access per clkref slot, shared by boot loader, Z80 and DMA.
// Priority is boot > starved DMA > CPU > DMA; starve_cnt forces DMA after STARVE CPU grants.
module sdram_slot_arbiter #(
    parameter int AW     = 23,
    parameter int STARVE = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          clkref,
    input  logic          boot_req,
    input  logic [AW-1:0] boot_addr,
    input  logic [7:0]    boot_din,
    output logic          boot_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_din,
    output logic [7:0]    dma_dout,
    output logic          dma_ack,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [1:0] NONE = 2'd0, BOOT = 2'd1, CPU = 2'd2, DMA = 2'd3;
    state_t        state;
    logic [1:0]    owner, winner;
    logic [3:0]    starve_cnt;
    logic          boot_el, cpu_el, dma_el, win_we;
    logic [AW-1:0] win_addr;
    logic [7:0]    win_din;
    always_comb begin
        // a requester whose ack is still high has not yet dropped its stale req
        boot_el  = boot_req && !boot_ack;
        cpu_el   = cpu_req && !cpu_ack;
        dma_el   = dma_req && !dma_ack;
        winner   = boot_el ? BOOT :
                   (dma_el && starve_cnt == 4'(STARVE)) ? DMA :
                   cpu_el ? CPU :
                   dma_el ? DMA : NONE;
        win_we   = winner == BOOT || (winner == CPU && cpu_we) || (winner == DMA && dma_we);
        win_addr = winner == BOOT ? boot_addr : winner == CPU ? cpu_addr : dma_addr;
        win_din  = winner == BOOT ? boot_din : winner == CPU ? cpu_din : dma_din;
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= NONE;
            starve_cnt <= '0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            boot_ack   <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_dout   <= 8'hFF;
            dma_dout   <= 8'hFF;
        end else begin
            boot_ack <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            if (!dma_req) starve_cnt <= '0;
            if (clkref) begin
                if (state == BUSY) begin
                    boot_ack <= owner == BOOT;
                    cpu_ack  <= owner == CPU;
                    dma_ack  <= owner == DMA;
                    if (mem_oe && owner == CPU) cpu_dout <= mem_dout;
                    if (mem_oe && owner == DMA) dma_dout <= mem_dout;
                end
                state  <= winner == NONE ? IDLE : BUSY;
                owner  <= winner;
                mem_oe <= winner != NONE && !win_we;
                mem_we <= win_we;
                if (winner != NONE) begin
                    mem_addr <= win_addr;
                    mem_din  <= win_din;
                end
                if (winner == DMA)
                    starve_cnt <= '0;
                else if (winner == CPU && dma_req && starve_cnt != 4'(STARVE))
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb_sdram_slot_arbiter: directed slot sequences; a posedge monitor checks grants and acks against scoreboard queues.
module tb_sdram_slot_arbiter;
    logic        clk_sys, reset, clkref;
    logic        boot_req, boot_ack, cpu_req, cpu_we, cpu_ack, dma_req, dma_we, dma_ack;
    logic [22:0] boot_addr, cpu_addr, dma_addr, mem_addr;
    logic [7:0]  boot_din, cpu_din, cpu_dout, dma_din, dma_dout, mem_din, mem_dout;
    logic        mem_oe, mem_we;
    logic [3:0]  phase;

    typedef struct {logic oe; logic we; logic [22:0] addr; logic [7:0] din;} grant_t;
    typedef struct {logic [2:0] acks; logic rd; logic [7:0] dout;} ack_t;
    grant_t grant_q[$];
    ack_t   ack_q[$];
    grant_t eg;
    ack_t   ea;
    int     checks = 0, errors = 0, cyc = 0, grant_cyc = 0;
    logic   mon_slot, mon_rst;
    logic [2:0] ack_v;

    sdram_slot_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .clkref(clkref),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_din(boot_din), .boot_ack(boot_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ack(dma_ack),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // one-cycle clkref every 16 clk_sys, changed on the falling edge
    initial begin
        phase  = 4'd0;
        clkref = 1'b0;
        forever begin
            @(negedge clk_sys);
            phase  = phase + 4'd1;
            clkref = (phase == 4'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_slot();
        do @(posedge clk_sys); while (clkref !== 1'b1);
        @(negedge clk_sys);
    endtask

    task automatic wait_ack(input int bitpos, input string tag);
        logic [2:0] a;
        int n;
        n = 0;
        do begin
            @(negedge clk_sys);
            a = {boot_ack, cpu_ack, dma_ack};
            n++;
        end while (!a[bitpos] && n < 40);
        chk(tag, 64'(a[bitpos]), 64'd1);
    endtask

    always @(posedge clk_sys) begin
        mon_slot = clkref;
        mon_rst  = reset;
        cyc++;
        #1;
        if (!mon_rst) begin
            ack_v = {boot_ack, cpu_ack, dma_ack};
            if (ack_v != 3'b000) begin
                chk("ack_expected", 64'(mon_slot && ack_q.size() != 0), 64'd1);
                if (ack_q.size() != 0) begin
                    ea = ack_q.pop_front();
                    chk("ack_who", 64'(ack_v), 64'(ea.acks));
                    if (ea.rd) chk("ack_dout", 64'(ack_v[1] ? cpu_dout : dma_dout), 64'(ea.dout));
                    chk("ack_latency", 64'(cyc - grant_cyc), 64'd16);
                end
            end
            if (mon_slot && (mem_oe || mem_we)) begin
                chk("grant_expected", 64'(grant_q.size() != 0), 64'd1);
                if (grant_q.size() != 0) begin
                    eg = grant_q.pop_front();
                    chk("grant_oe_we_addr_din", 64'({mem_oe, mem_we, mem_addr, mem_din}),
                        64'({eg.oe, eg.we, eg.addr, eg.din}));
                end
                grant_cyc = cyc;
            end
        end
    end

    initial begin
        reset = 1'b1;
        {boot_req, cpu_req, cpu_we, dma_req, dma_we} = '0;
        boot_addr = '0; cpu_addr = '0; dma_addr = '0;
        boot_din = '0; cpu_din = '0; dma_din = '0; mem_dout = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_mem_oe", 64'(mem_oe), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_din", 64'(mem_din), 64'd0);
        chk("rst_acks", 64'({boot_ack, cpu_ack, dma_ack}), 64'd0);
        chk("rst_cpu_dout", 64'(cpu_dout), 64'hFF);
        chk("rst_dma_dout", 64'(dma_dout), 64'hFF);
        chk("rst_starve_cnt", 64'(dut.starve_cnt), 64'd0);
        reset = 1'b0;

        // single CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h004000; cpu_din = 8'h00; mem_dout = 8'hA5;
        grant_q.push_back('{1'b1, 1'b0, 23'h004000, 8'h00});
        ack_q.push_back('{3'b010, 1'b1, 8'hA5});
        next_slot();
        cpu_req = 1'b0;
        wait_ack(1, "cpu_read_ack_timeout");

        // boot and CPU raised together: boot first, CPU granted on boot's completion edge
        boot_req = 1'b1; boot_addr = 23'h400000; boot_din = 8'h3C;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000123; cpu_din = 8'h5A;
        grant_q.push_back('{1'b0, 1'b1, 23'h400000, 8'h3C});
        grant_q.push_back('{1'b0, 1'b1, 23'h000123, 8'h5A});
        ack_q.push_back('{3'b100, 1'b0, 8'h00});
        ack_q.push_back('{3'b010, 1'b0, 8'h00});
        next_slot();
        boot_req = 1'b0;
        next_slot();
        chk("boot_ack_with_cpu_grant", 64'(boot_ack), 64'd1);
        chk("cpu_grant_addr", 64'(mem_addr), 64'h000123);
        cpu_req = 1'b0;
        wait_ack(1, "cpu_write_ack_timeout");

        // starvation guard: CPU, CPU, CPU, DMA, CPU
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000200; cpu_din = 8'h00; mem_dout = 8'h5C;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h020000; dma_din = 8'h11;
        for (int i = 0; i < 3; i++) grant_q.push_back('{1'b1, 1'b0, 23'h000200, 8'h00});
        grant_q.push_back('{1'b0, 1'b1, 23'h020000, 8'h11});
        grant_q.push_back('{1'b1, 1'b0, 23'h000200, 8'h00});
        for (int i = 0; i < 3; i++) ack_q.push_back('{3'b010, 1'b1, 8'h5C});
        ack_q.push_back('{3'b001, 1'b0, 8'h00});
        ack_q.push_back('{3'b010, 1'b1, 8'h5C});
        repeat (3) next_slot();
        chk("starve_cnt_saturated", 64'(dut.starve_cnt), 64'd3);
        next_slot();
        chk("starve_cnt_after_dma", 64'(dut.starve_cnt), 64'd0);
        dma_req = 1'b0;
        next_slot();
        cpu_req = 1'b0;
        wait_ack(1, "starve_last_cpu_ack_timeout");

        // DMA write then read of the same byte, back to back
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h010000; dma_din = 8'h77;
        grant_q.push_back('{1'b0, 1'b1, 23'h010000, 8'h77});
        grant_q.push_back('{1'b1, 1'b0, 23'h010000, 8'h77});
        ack_q.push_back('{3'b001, 1'b0, 8'h00});
        ack_q.push_back('{3'b001, 1'b1, 8'h77});
        next_slot();
        dma_we = 1'b0; mem_dout = 8'h77;
        next_slot();
        dma_req = 1'b0;
        wait_ack(0, "dma_read_ack_timeout");
        chk("dma_dout_hold", 64'(dma_dout), 64'h77);

        // reset five cycles into a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h004000; mem_dout = 8'hEE;
        grant_q.push_back('{1'b1, 1'b0, 23'h004000, 8'h00});
        next_slot();
        repeat (4) @(negedge clk_sys);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("mid_rst_mem_oe", 64'(mem_oe), 64'd0);
        chk("mid_rst_cpu_dout", 64'(cpu_dout), 64'hFF);
        chk("mid_rst_cpu_ack", 64'(cpu_ack), 64'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        cpu_req = 1'b0;

        // idle slots
        for (int i = 0; i < 10; i++) begin
            next_slot();
            chk("idle_oe_we", 64'({mem_oe, mem_we}), 64'd0);
            chk("idle_acks", 64'({boot_ack, cpu_ack, dma_ack}), 64'd0);
        end
        chk("grant_q_drained", 64'(grant_q.size()), 64'd0);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
